// File: rtl/mpeg2_out_axis_packer.sv
// MPEG2 encoder output packer: buffers 256-bit encoder words in a block-RAM FIFO
// and serialises each word into four little-endian 64-bit AXI-Stream beats.
module mpeg2_out_axis_packer #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_en,
    input  logic                  i_last,
    input  logic [255:0]          i_data,
    input  logic                  i_clear_overflow,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);

    // FIFO storage: {last, data}; contents are never reset
    logic [256:0]            mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [1:0]              beat_q, beat_d;
    logic [255:0]            hold_data_q;
    logic                    hold_last_q;

    logic                    full_s;
    logic                    empty_s;
    logic                    wr_acc_s;
    logic                    drop_s;
    logic                    hs_s;
    logic                    word_done_s;
    logic                    pop_s;
    logic [255:0]            swapped_s;
    logic [63:0]             beat_data_s;

    // Handshake and FIFO status decode
    always_comb begin
        full_s      = (level_q == FULL_LEVEL);
        empty_s     = (level_q == LEVEL_ZERO);
        wr_acc_s    = i_en & ~full_s;
        drop_s      = i_en & full_s;
        hs_s        = hold_valid_q & m_axis_tready;
        word_done_s = hs_s & (beat_q == 2'd3);
        // the holding register is refilled on the same edge its last beat leaves,
        // which keeps consecutive words gap-free
        pop_s       = (~hold_valid_q | word_done_s) & ~empty_s;
    end

    // Next-state logic for pointers, level, beat counter and overflow flag
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        hold_valid_d = hold_valid_q;
        beat_d       = beat_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        if (pop_s) begin
            hold_valid_d = 1'b1;
            beat_d       = 2'd0;
        end else if (word_done_s) begin
            hold_valid_d = 1'b0;
            beat_d       = 2'd0;
        end else if (hs_s) begin
            hold_valid_d = hold_valid_q;
            beat_d       = beat_q + 2'd1;
        end else begin
            hold_valid_d = hold_valid_q;
            beat_d       = beat_q;
        end

        // a drop in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            level_q      <= LEVEL_ZERO;
            overflow_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            beat_q       <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            hold_valid_q <= hold_valid_d;
            beat_q       <= beat_d;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= {i_last, i_data};
        end
    end

    // Synchronous read port doubles as the holding register
    always_ff @(posedge clk) begin
        if (pop_s) begin
            {hold_last_q, hold_data_q} <= mem_q[rd_ptr_q];
        end
    end

    // Big-endian word to little-endian beat selection; idle output is forced to zero
    always_comb begin
        swapped_s   = 256'd0;
        beat_data_s = 64'd0;
        for (int j = 0; j < 32; j++) begin
            swapped_s[j*8 +: 8] = hold_data_q[(31-j)*8 +: 8];
        end
        case (beat_q)
            2'd0:    beat_data_s = swapped_s[63:0];
            2'd1:    beat_data_s = swapped_s[127:64];
            2'd2:    beat_data_s = swapped_s[191:128];
            2'd3:    beat_data_s = swapped_s[255:192];
            default: beat_data_s = 64'd0;
        endcase
        if (hold_valid_q) begin
            m_axis_tdata = beat_data_s;
            m_axis_tlast = hold_last_q & (beat_q == 2'd3);
        end else begin
            m_axis_tdata = 64'd0;
            m_axis_tlast = 1'b0;
        end
    end

    assign m_axis_tvalid = hold_valid_q;
    assign m_axis_tkeep  = 8'hFF;
    assign o_level       = level_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_mpeg2_out_axis_packer.sv
// Self-checking bench for mpeg2_out_axis_packer: a word-queue model predicts the
// output stream every cycle, with literal checks pinning latency, mapping and overflow.
module tb_mpeg2_out_axis_packer;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           i_en = 1'b0;
    logic           i_last = 1'b0;
    logic [255:0]   i_data = 256'd0;
    logic           i_clear_overflow = 1'b0;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tvalid;
    logic [63:0]    m_axis_tdata;
    logic [7:0]     m_axis_tkeep;
    logic           m_axis_tlast;
    logic [DL2:0]   o_level;
    logic           o_overflow;

    mpeg2_out_axis_packer #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_last(i_last), .i_data(i_data),
        .i_clear_overflow(i_clear_overflow),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .o_level(o_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of stored words, the word on the output, and beats left on it
    logic [256:0] mq [$];
    logic [256:0] hw = 257'd0;
    int           rem = 0;
    logic         m_ovf = 1'b0;
    int           hs_cnt = 0;
    int           sz;
    logic         stall_seen = 1'b0;

    function automatic logic [63:0] beat_of(input logic [256:0] w, input int k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(31 - (8*k + i))*8 +: 8];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete();
                rem = 0;
                m_ovf = 1'b0;
                stall_seen = 1'b0;
            end else begin
                sz = mq.size();
                stall_seen = (rem > 0) && !m_axis_tready;
                if (rem > 0 && m_axis_tready) begin
                    rem--;
                    hs_cnt++;
                end
                if (rem == 0 && sz > 0) begin
                    hw  = mq.pop_front();
                    rem = 4;
                end
                if (i_en && sz == DEPTH) m_ovf = 1'b1;
                else if (i_clear_overflow) m_ovf = 1'b0;
                if (i_en && sz < DEPTH) mq.push_back({i_last, i_data});
            end
        end
    end

    // Per-cycle comparison against the model
    logic [63:0] prev_tdata = 64'd0;
    logic        prev_tlast = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                chk("tvalid", m_axis_tvalid, rem > 0);
                chk("level", o_level, mq.size());
                chk("overflow", o_overflow, m_ovf);
                chk("tkeep", m_axis_tkeep, 64'hFF);
                if (rem > 0) begin
                    chk("tdata", m_axis_tdata, beat_of(hw, 4 - rem));
                    chk("tlast", m_axis_tlast, hw[256] && (rem == 1));
                end
                if (stall_seen) begin
                    chk("stall_tdata", m_axis_tdata, prev_tdata);
                    chk("stall_tlast", m_axis_tlast, prev_tlast);
                    chk("stall_tvalid", m_axis_tvalid, 1);
                end
            end
            prev_tdata = m_axis_tdata;
            prev_tlast = m_axis_tlast;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while ((m_axis_tvalid !== 1'b0 || o_level != 0) && c < 3000) begin
            step;
            c++;
        end
        chk(nm, (m_axis_tvalid === 1'b0) && (o_level == 0), 1);
    endtask

    int stream_cyc = 0, first_v = -1, last_v = -1, vcnt = 0;
    task automatic step_stream;
        step;
        stream_cyc++;
        chk("stream_level_le1", o_level <= 1, 1);
        if (m_axis_tvalid === 1'b1) begin
            if (first_v < 0) first_v = stream_cyc;
            last_v = stream_cyc;
            vcnt++;
        end
    endtask

    logic [63:0] exp1 [4];
    int hs0, sent, c;
    logic [256:0] w1;

    initial begin
        exp1[0] = 64'h0706050403020100;
        exp1[1] = 64'h0F0E0D0C0B0A0908;
        exp1[2] = 64'h1716151413121110;
        exp1[3] = 64'h1F1E1D1C1B1A1918;

        // Reset values
        step; step;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_level", o_level, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_tkeep", m_axis_tkeep, 64'hFF);
        rstn = 1'b1;
        step;

        // Single word, bytes 0x00..0x1F
        m_axis_tready = 1'b1;
        for (int j = 0; j < 32; j++) i_data[(31-j)*8 +: 8] = 8'(j);
        i_en = 1'b1; i_last = 1'b1;
        step;
        i_en = 1'b0; i_last = 1'b0;
        chk("single_n1_tvalid", m_axis_tvalid, 0);
        for (int k = 0; k < 4; k++) begin
            step;
            chk("single_tvalid", m_axis_tvalid, 1);
            chk("single_tdata", m_axis_tdata, exp1[k]);
            chk("single_tlast", m_axis_tlast, (k == 3) ? 1 : 0);
        end
        step;
        chk("single_idle", m_axis_tvalid, 0);

        // Streaming: 100 words, one every 4 cycles
        hs0 = hs_cnt;
        for (int w = 0; w < 100; w++) begin
            i_en = 1'b1; i_last = (w == 99); i_data = rnd256();
            step_stream;
            i_en = 1'b0; i_last = 1'b0;
            step_stream; step_stream; step_stream;
        end
        for (int k = 0; k < 10; k++) step_stream;
        chk("stream_beats", hs_cnt - hs0, 400);
        chk("stream_valid_cycles", vcnt, 400);
        chk("stream_no_gap", last_v - first_v + 1, 400);
        wait_drain("stream_drain");

        // Backpressure: random tready, 64 words
        hs0 = hs_cnt; sent = 0; c = 0;
        while (sent < 64 && c < 5000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if (mq.size() < 12 && $urandom_range(0, 2) == 0) begin
                i_en = 1'b1; i_last = (sent == 63); i_data = rnd256();
                sent++;
            end else begin
                i_en = 1'b0; i_last = 1'b0;
            end
            step;
            c++;
        end
        i_en = 1'b0; i_last = 1'b0;
        chk("bp_sent", sent, 64);
        c = 0;
        while ((m_axis_tvalid !== 1'b0 || o_level != 0) && c < 3000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step;
            c++;
        end
        m_axis_tready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_beats", hs_cnt - hs0, 256);

        // Overflow with tready low
        m_axis_tready = 1'b0;
        for (int w = 1; w <= 20; w++) begin
            i_en = 1'b1; i_data = rnd256();
            step;
            if (w == 17) chk("ovf_after17", o_overflow, 0);
            if (w == 18) chk("ovf_after18", o_overflow, 1);
        end
        i_en = 1'b0;
        chk("ovf_level_sat", o_level, 16);
        chk("ovf_flag", o_overflow, 1);
        i_clear_overflow = 1'b1;
        step;
        i_clear_overflow = 1'b0;
        chk("clear_alone", o_overflow, 0);
        i_clear_overflow = 1'b1; i_en = 1'b1; i_data = rnd256();
        step;
        i_clear_overflow = 1'b0; i_en = 1'b0;
        chk("clear_vs_drop", o_overflow, 1);
        chk("ovf_level_hold", o_level, 16);
        hs0 = hs_cnt;
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_drained_beats", hs_cnt - hs0, 68);

        // Reset during beat 2 with 5 words queued
        m_axis_tready = 1'b0;
        for (int w = 0; w < 6; w++) begin
            i_en = 1'b1; i_data = rnd256();
            if (w == 0) w1 = {1'b0, i_data};
            step;
        end
        i_en = 1'b0;
        m_axis_tready = 1'b1;
        step; step;
        m_axis_tready = 1'b0;
        chk("rstmid_level5", o_level, 5);
        chk("rstmid_beat2", m_axis_tdata, beat_of(w1, 2));
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_tvalid", m_axis_tvalid, 0);
        chk("rstmid_level", o_level, 0);
        chk("rstmid_overflow", o_overflow, 0);
        step;
        rstn = 1'b1;
        i_en = 1'b1; i_last = 1'b1; i_data = {64'h0000_01B3_1122_3344, 192'd0};
        step;
        i_en = 1'b0; i_last = 1'b0;
        chk("post_rst_n1", m_axis_tvalid, 0);
        step;
        chk("post_rst_tvalid", m_axis_tvalid, 1);
        chk("post_rst_beat0", m_axis_tdata, 64'h4433_2211_B301_0000);
        m_axis_tready = 1'b1;
        wait_drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
